// File: rtl/ldpc_pkg.sv
// Shared types and sizing helpers for the LDPC parity sequencer and its datapath.
package ldpc_pkg;

    localparam int NB_DEF = 4;
    localparam int NP_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ACC,
        S_DONE
    } state_t;

    // Counter width that stays legal (>= 1 bit) even for a single-entry range.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int np, input int nb);
        return cnt_w(np * nb);
    endfunction

    // AND-XOR dot-product cell: message bit i meets coefficient bit 7-i.
    function automatic logic dot8(input logic [7:0] m, input logic [7:0] g, input logic l_ref);
        logic r;
        r = l_ref;
        for (int i = 0; i < 8; i++) begin
            r = r ^ (m[i] & g[7-i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/ldpc_parity_dp.sv
// Datapath for ldpc_parity_seq: message byte store, running accumulator bit,
// the dot-product cell and the parity output register.
module ldpc_parity_dp
    import ldpc_pkg::*;
#(
    parameter int NB = NB_DEF,
    parameter int NP = NP_DEF,
    localparam int JW = cnt_w(NB),
    localparam int PW = cnt_w(NP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          msg_wr,
    input  logic [JW-1:0] msg_idx,
    input  logic [7:0]    msg_byte,
    input  logic [JW-1:0] rd_idx,
    input  logic [7:0]    g_data,
    input  logic          acc_en,
    input  logic          acc_clr,
    input  logic          par_wr,
    input  logic [PW-1:0] par_idx,
    output logic [NP-1:0] parity_data
);

    logic [7:0] msg_mem [NB];
    logic       acc_q;
    logic       d_out;

    // NOTE: the message store has no reset; the FSM only reads chunks written in the current frame.
    always_ff @(posedge clk) begin
        if (msg_wr) begin
            msg_mem[msg_idx] <= msg_byte;
        end
    end

    assign d_out = dot8(msg_mem[rd_idx], g_data, acc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= 1'b0;
            parity_data <= '0;
        end else begin
            if (acc_clr) begin
                acc_q <= 1'b0;
            end else if (acc_en) begin
                acc_q <= d_out;
            end
            if (par_wr) begin
                parity_data[par_idx] <= d_out;
            end
        end
    end

endmodule

// File: rtl/ldpc_parity_seq.sv
// LDPC parity sequencer: FSM and row/chunk counters driving ldpc_parity_dp.
// Optional abort input enabled by defining LDPC_PARITY_SEQ_ABORT_EN.
module ldpc_parity_seq
    import ldpc_pkg::*;
#(
    parameter int NB = NB_DEF,
    parameter int NP = NP_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef LDPC_PARITY_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    input  logic [7:0]               msg_data,
    input  logic                     msg_valid,
    output logic                     msg_ready,
    output logic [addr_w(NP,NB)-1:0] g_addr,
    input  logic [7:0]               g_data,
    output logic [NP-1:0]            parity_data,
    output logic                     parity_valid,
    input  logic                     parity_ready,
    output logic                     busy
);

    localparam int AW = addr_w(NP, NB);
    localparam int JW = cnt_w(NB);
    localparam int PW = cnt_w(NP);

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [JW-1:0] j_q, j_d;
    logic [AW-1:0] g_addr_q;
    logic          msg_wr, acc_en, acc_clr, par_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            j_q      <= '0;
            g_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            j_q      <= j_d;
            g_addr_q <= g_addr;
        end
    end

    // j doubles as the chunk write index while loading the message.
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        j_d          = j_q;
        msg_ready    = 1'b0;
        busy         = 1'b1;
        parity_valid = 1'b0;
        msg_wr       = 1'b0;
        acc_en       = 1'b0;
        acc_clr      = 1'b0;
        par_wr       = 1'b0;
        g_addr       = g_addr_q;
        case (state_q)
            S_IDLE: begin
                msg_ready = 1'b1;
                busy      = 1'b0;
                acc_clr   = 1'b1;
                if (msg_valid) begin
                    msg_wr = 1'b1;
                    if (NB == 1) begin
                        j_d     = '0;
                        state_d = S_FETCH;
                    end else begin
                        j_d     = JW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    msg_wr = 1'b1;
                    if (j_q == JW'(NB - 1)) begin
                        j_d     = '0;
                        p_d     = '0;
                        state_d = S_FETCH;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            S_FETCH: begin
                g_addr  = AW'(p_q) * AW'(NB) + AW'(j_q);
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_en = 1'b1;
                if (j_q == JW'(NB - 1)) begin
                    par_wr  = 1'b1;
                    acc_clr = 1'b1;
                    j_d     = '0;
                    if (p_q == PW'(NP - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        p_d     = p_q + PW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    j_d     = j_q + JW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                parity_valid = 1'b1;
                if (parity_ready) begin
                    p_d     = '0;
                    j_d     = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef LDPC_PARITY_SEQ_ABORT_EN
        if (abort) begin
            state_d = S_IDLE;
            p_d     = '0;
            j_d     = '0;
            msg_wr  = 1'b0;
            par_wr  = 1'b0;
            acc_clr = 1'b1;
        end
`endif
    end

    ldpc_parity_dp #(
        .NB (NB),
        .NP (NP)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .msg_wr      (msg_wr),
        .msg_idx     (j_q),
        .msg_byte    (msg_data),
        .rd_idx      (j_q),
        .g_data      (g_data),
        .acc_en      (acc_en),
        .acc_clr     (acc_clr),
        .par_wr      (par_wr),
        .par_idx     (p_q),
        .parity_data (parity_data)
    );

endmodule

// File: tb/tb_ldpc_parity_seq.sv
// Scoreboard bench for ldpc_parity_seq (NB=4, NP=8) with a 1-cycle coefficient ROM.
// Covers the abort path when LDPC_PARITY_SEQ_ABORT_EN is defined.
module tb_ldpc_parity_seq;
    import ldpc_pkg::*;

    localparam int NB = 4;
    localparam int NP = 8;
    localparam int AW = addr_w(NP, NB);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    msg_data;
    logic          msg_valid;
    logic          msg_ready;
    logic [AW-1:0] g_addr;
    logic [7:0]    g_data;
    logic [NP-1:0] parity_data;
    logic          parity_valid;
    logic          parity_ready;
    logic          busy;
`ifdef LDPC_PARITY_SEQ_ABORT_EN
    logic          abort;
`endif

    logic [7:0] rom [NP*NB];
    logic [7:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_edge = 0;
    logic prev_valid = 1'b0;

    ldpc_parity_seq #(.NB(NB), .NP(NP)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef LDPC_PARITY_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .msg_data     (msg_data),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .g_addr       (g_addr),
        .g_data       (g_data),
        .parity_data  (parity_data),
        .parity_valid (parity_valid),
        .parity_ready (parity_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        g_data <= rom[g_addr];
        cyc    <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented parity word against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (msg_valid && msg_ready) acc_edge = cyc + 1;
            if (parity_valid && !prev_valid) check("latency", cyc - acc_edge, 2 * NB * NP);
            if (parity_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected parity_valid", 32'd1, 32'd0);
                end else begin
                    check("parity_data", 32'(parity_data), 32'(exp_q[0]));
                    check("msg_ready in DONE", 32'(msg_ready), 32'd0);
                    check("busy in DONE", 32'(busy), 32'd1);
                    if (parity_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_valid = parity_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [31:0] msg, input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            msg_data  = msg[31-8*k -: 8];
            msg_valid = 1'b1;
            t = 0;
            while (!msg_ready && t < 200) begin
                tick();
                t++;
            end
            if (!msg_ready) check("msg_ready timeout", 32'd0, 32'd1);
            tick();
        end
        msg_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] msg, input logic [7:0] exp, input int hold, input bit noise);
        int t;
        exp_q.push_back(exp);
        send_bytes(msg, NB);
        if (noise) begin
            msg_valid = 1'b1;
            msg_data  = 8'hFF;
        end
        t = 0;
        while (!parity_valid && t < 500) begin
            tick();
            t++;
        end
        check("parity_valid timeout", 32'(parity_valid), 32'd1);
        repeat (hold) tick();
        msg_valid    = 1'b0;
        parity_ready = 1'b1;
        tick();
        parity_ready = 1'b0;
        check("parity_valid after handshake", 32'(parity_valid), 32'd0);
        check("busy after handshake", 32'(busy), 32'd0);
    endtask

    task automatic rom_all(input logic [7:0] v);
        for (int a = 0; a < NP*NB; a++) rom[a] = v;
    endtask

    // Only chunk 0 bit 7 is set in the message, so row p sees coefficient bit 0 of byte 0.
    task automatic rom_rows(input logic [7:0] pat);
        for (int p = 0; p < NP; p++)
            for (int j = 0; j < NB; j++)
                rom[p*NB+j] = (j == 0) ? {7'h7F, pat[p]} : 8'hFF;
    endtask

    // Only chunk 3 bit 0 is set in the message, so row p sees coefficient bit 7 of byte 3.
    task automatic rom_cols(input logic [7:0] pat);
        for (int p = 0; p < NP; p++)
            for (int j = 0; j < NB; j++)
                rom[p*NB+j] = (j == NB - 1) ? {pat[p], 7'h7F} : 8'hFF;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst          = 1'b1;
        msg_valid    = 1'b0;
        msg_data     = 8'h00;
        parity_ready = 1'b0;
`ifdef LDPC_PARITY_SEQ_ABORT_EN
        abort        = 1'b0;
`endif
        rom_all(8'h00);
        repeat (3) tick();
        check("reset msg_ready", 32'(msg_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset parity_valid", 32'(parity_valid), 32'd0);
        check("reset parity_data", 32'(parity_data), 32'd0);
        check("reset g_addr", 32'(g_addr), 32'd0);
        rst = 1'b0;
        tick();

        for (int a = 0; a < NP*NB; a++) rom[a] = 8'($urandom);
        run_frame(32'h00000000, 8'h00, 0, 1'b0);

        rom_all(8'h01);
        run_frame(32'h80000000, 8'hFF, 0, 1'b0);
        run_frame(32'hFFFFFFFF, 8'h00, 0, 1'b0);

        rom_all(8'h03);
        run_frame(32'h81818100, 8'hFF, 10, 1'b1);

        send_bytes(32'hFFFF0000, 2);
        rst = 1'b1;
        #1;
        check("mid-frame rst busy", 32'(busy), 32'd0);
        check("mid-frame rst msg_ready", 32'(msg_ready), 32'd1);
        check("mid-frame rst parity_valid", 32'(parity_valid), 32'd0);
        check("mid-frame rst parity_data", 32'(parity_data), 32'd0);
        check("mid-frame rst g_addr", 32'(g_addr), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        rom_all(8'h01);
        run_frame(32'h80000000, 8'hFF, 0, 1'b0);

        rom_rows(8'hA5);
        run_frame(32'h80000000, 8'hA5, 2, 1'b0);
        rom_cols(8'h3C);
        run_frame(32'h00000001, 8'h3C, 0, 1'b0);

`ifdef LDPC_PARITY_SEQ_ABORT_EN
        rom_rows(8'h5A);
        send_bytes(32'h80000000, NB);
        t = 0;
        while (g_addr != AW'(3 * NB) && t < 200) begin
            tick();
            t++;
        end
        check("reach row 3", 32'(g_addr), 32'(3 * NB));
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort msg_ready", 32'(msg_ready), 32'd1);
        check("abort parity_valid", 32'(parity_valid), 32'd0);
        run_frame(32'h80000000, 8'h5A, 0, 1'b0);
`endif

        repeat (5) tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ldpc_parity_seq.md
LDPC_PARITY_SEQ -- requirements
Module: ldpc_parity_seq

Interface
REQ-001 Parameter NB, default 4: message length in bytes; chunk 0 is the first byte received.
REQ-002 Parameter NP, default 8: number of parity bits, one generator row per parity bit.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 msg_data  in  8  message byte.
REQ-006 msg_valid  in  1  msg_data is valid.
REQ-007 msg_ready  out  1  block accepts a byte; a byte transfers when valid and ready are both high on a clock edge.
REQ-008 g_addr  out  clog2(NP*NB)  generator-coefficient address, equal to p*NB+j.
REQ-009 g_data  in  8  coefficient byte, valid one cycle after g_addr is presented.
REQ-010 parity_data  out  NP  parity word; bit p is parity row p.
REQ-011 parity_valid  out  1  parity_data is valid.
REQ-012 parity_ready  in  1  downstream accepts parity_data.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, LOAD, FETCH, ACC, DONE.
REQ-015 IDLE: msg_ready=1; the first accepted byte is stored as chunk 0 and the FSM moves to LOAD (or straight to FETCH when NB=1).
REQ-016 LOAD: msg_ready=1; bytes are stored at consecutive chunk indices; the byte that fills chunk NB-1 moves the FSM to FETCH with p=0, j=0 and acc=0.
REQ-017 FETCH: g_addr=p*NB+j is driven for one cycle, then the FSM moves to ACC.
REQ-018 ACC: dot-product cell inputs are d_in=msg[j], buffer=g_data (unmodified, so bit i of the message pairs with bit 7-i of the coefficient) and L_ref=acc; the cell output d_out is written to acc.
REQ-019 ACC exit when j<NB-1: j increments and the FSM returns to FETCH.
REQ-020 ACC exit when j=NB-1: d_out is written to parity_data[p], acc is cleared and j=0; if p<NP-1, p increments and the FSM goes to FETCH, otherwise it goes to DONE.
REQ-021 DONE: parity_valid=1 and parity_data is held stable until parity_ready=1; on that handshake the FSM goes to IDLE, p and j clear, and parity_valid falls the next cycle.
REQ-022 msg_ready=0 in FETCH, ACC and DONE; msg_valid is ignored in those states.
REQ-023 Latency from the last message byte accepted to parity_valid: exactly 2*NB*NP cycles.
REQ-024 p and j never exceed NP-1 and NB-1; wrap to 0 happens only as stated in REQ-020 and REQ-021.
REQ-025 g_addr holds its last value outside FETCH.

Reset
REQ-026 While rst is high, at any time including mid-frame: state=IDLE; p, j and acc are 0; parity_data=0; parity_valid=0; busy=0; msg_ready=1; g_addr=0. Any partial frame is discarded.

Configuration
REQ-027 Macro LDPC_PARITY_SEQ_ABORT_EN defined: adds input abort (1 bit); abort=1 in any state moves the FSM to IDLE on the next edge, clears p, j and acc, and drops parity_valid; parity_data is retained.
REQ-028 Macro not defined: no abort port exists; the only way to end a frame early is rst.

Structure
REQ-029 A shared package ldpc_pkg holds the FSM state enumeration, the default NB/NP constants, and the address-width function.
REQ-030 The datapath is one sub-module, ldpc_parity_dp: message byte register file, acc flop, and the 8-bit AND-XOR dot-product cell. ldpc_parity_seq holds only the FSM and counters.

Verification (NB=4, NP=8, coefficient ROM model with 1-cycle read latency)
REQ-031 Message 00 00 00 00, ROM random -> parity_data=0x00, parity_valid rises 64 cycles after the last byte.
REQ-032 Message 80 00 00 00, ROM all 0x01 -> parity_data=0xFF.
REQ-033 Message FF FF FF FF, ROM all 0x01 -> parity_data=0x00 (four ones cancel).
REQ-034 parity_ready held low 10 cycles in DONE -> parity_valid and parity_data stable throughout, msg_ready=0; frame completes after ready rises.
REQ-035 rst pulsed after 2 message bytes, then a full frame 80 00 00 00 with ROM all 0x01 -> 0xFF; no residue from the aborted frame.
REQ-036 With LDPC_PARITY_SEQ_ABORT_EN, abort during ACC of row 3 -> IDLE the next cycle, busy=0; the following frame computes correctly.
